// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Purpose  : Bundles the producer request bus, the FIFO write port and the
//             grant/accept handshake shared between the write arbiter and
//             the producers/FIFO around it.
//  Ports    : master - arbiter view (consumes requests, drives FIFO port)
//             slave  - producer/FIFO view (drives requests, observes grants)
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic                   fifo_full;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       accept;
  logic                   fifo_cs;
  logic                   fifo_we;
  logic [WIDTH-1:0]       fifo_din;

  modport master (
    input  req, req_data, req_last, fifo_full,
    output gnt, accept, fifo_cs, fifo_we, fifo_din
  );

  modport slave (
    output req, req_data, req_last, fifo_full,
    input  gnt, accept, fifo_cs, fifo_we, fifo_din
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter letting N_REQ producers share one FIFO
//             write port. A grant lasts until the owner marks its last beat,
//             MAX_BURST beats have been accepted, or the owner withdraws.
//             One idle cycle always separates consecutive grants.
//  Ports    : clk_i   - clock, rising edge
//             rst_ni  - asynchronous active-low reset
//             bus     - request bus / FIFO write port (master modport)
//                       req, req_data, req_last, fifo_full  (in)
//                       gnt, accept, fifo_cs, fifo_we, fifo_din (out)
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_winner_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] gnt_q;

  logic [IW-1:0]    owner_d;
  logic             found_d;
  logic [IW-1:0]    cand;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic             owner_req;
  logic             owner_last;
  logic             beat_we;
  logic             burst_done;

  // Unpack the flat producer data bus so the owner's word is a plain index.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: start one past the previous winner and wrap, so the
  // most recent owner has the lowest priority in the next arbitration.
  always_comb begin
    found_d = 1'b0;
    owner_d = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last_winner_q) + i) % N_REQ);
      if (!found_d && bus.req[cand]) begin
        found_d = 1'b1;
        owner_d = cand;
      end
    end
  end

  assign owner_req  = bus.req[owner_q];
  assign owner_last = bus.req_last[owner_q];
  assign beat_we    = (state_q == S_GRANT) && owner_req && !bus.fifo_full;
  assign burst_done = owner_last || ((cnt_q + CW'(1)) == CW'(MAX_BURST));

  // gnt_q is one-hot on owner_q throughout GRANT, so masking it with the
  // write strobe yields the one-hot accept vector directly.
  assign bus.gnt      = gnt_q;
  assign bus.accept   = gnt_q & {N_REQ{beat_we}};
  assign bus.fifo_we  = beat_we;
  assign bus.fifo_cs  = (state_q == S_GRANT);
  assign bus.fifo_din = (state_q == S_GRANT) ? data_arr[owner_q] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      last_winner_q <= IW'(N_REQ - 1);
      cnt_q         <= '0;
      gnt_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (found_d) begin
            state_q <= S_GRANT;
            owner_q <= owner_d;
            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << owner_d;
          end else begin
            gnt_q <= '0;
          end
        end
        S_GRANT: begin
          if (!owner_req) begin
            // Producer withdrew: release without writing this cycle.
            state_q       <= S_IDLE;
            last_winner_q <= owner_q;
            gnt_q         <= '0;
          end else if (beat_we) begin
            cnt_q <= cnt_q + CW'(1);
            if (burst_done) begin
              state_q       <= S_IDLE;
              last_winner_q <= owner_q;
              gnt_q         <= '0;
            end
          end
          // fifo_full with owner still requesting: hold everything.
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter (N_REQ=4, WIDTH=32,
//             MAX_BURST=4). Producer i presents {8'hD0, 8'(i), beat#} and
//             advances beat# on each accepted beat; FIFO writes are captured
//             and checked per producer for order, duplication and loss.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(
    .N_REQ     (N_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] next_beat [N_REQ];
  logic [31:0] cap_q [$];
  logic        we_full_seen = 1'b0;
  logic        onehot_bad   = 1'b0;

  always_comb begin
    bus.req_data = '0;
    for (int i = 0; i < N_REQ; i++)
      bus.req_data[i*WIDTH +: WIDTH] = {8'hD0, 8'(i), next_beat[i]};
  end

  // Producer model and FIFO capture.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) next_beat[i] <= 16'd0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (bus.accept[i]) next_beat[i] <= next_beat[i] + 16'd1;
      if (bus.fifo_we) cap_q.push_back(bus.fifo_din);
      if (bus.fifo_we && bus.fifo_full) we_full_seen <= 1'b1;
    end
    if ($countones(bus.gnt) > 1 || $countones(bus.accept) > 1) onehot_bad <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic f);
    @(negedge clk);
    bus.req = r; bus.req_last = l; bus.fifo_full = f;
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = r; bus.req_last = '0; bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                         input logic we, input logic cs, input logic [31:0] d);
    check({tag, ".gnt"},    32'(bus.gnt),     32'(g));
    check({tag, ".accept"}, 32'(bus.accept),  32'(a));
    check({tag, ".we"},     32'(bus.fifo_we), 32'(we));
    check({tag, ".cs"},     32'(bus.fifo_cs), 32'(cs));
    check({tag, ".din"},    bus.fifo_din,     d);
  endtask

  // Drain captured writes; per producer the beat numbers must be 0,1,2,...
  task automatic drain_check(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
    int exp_n [4];
    int sbn [4];
    logic [31:0] w;
    int p;
    exp_n = '{e0, e1, e2, e3};
    sbn   = '{0, 0, 0, 0};
    while (cap_q.size() > 0) begin
      w = cap_q.pop_front();
      p = int'(w[17:16]);
      check({tag, ".tag"}, {8'h00, w[31:18], 2'b00}, {8'h00, 8'hD0, 6'h00, 2'b00});
      check({tag, ".seq"}, 32'(w[15:0]), 32'(sbn[p]));
      sbn[p]++;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.count%0d", tag, i), 32'(sbn[i]), 32'(exp_n[i]));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  gnt;
    logic [3:0]  acc;
    logic        we;
    logic        cs;
    logic [31:0] din;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req     last    f     gnt     acc     we    cs    din
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hD000_0000};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hD000_0001};
    tbl[3]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hD000_0002};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[5]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 32'hD001_0000};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 32'hD001_0001};
    tbl[8]  = '{4'b0101, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 32'hD001_0002};
    tbl[9]  = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[10] = '{4'b0101, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 32'hD002_0000};
    tbl[11] = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 32'hD002_0001};
    tbl[12] = '{4'b0101, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 32'hD002_0001};
    tbl[13] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[14] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hD000_0003};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};

    // Outputs are forced low while reset is held, even with requests present.
    rst_n = 1'b0;
    bus.req = 4'b1111; bus.req_last = 4'b1111; bus.fifo_full = 1'b0;
    @(negedge clk); #1;
    chk_out("in_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

    // Directed vector table: short packet, withdrawal, stall, round robin.
    do_reset(4'b0000);
    for (int k = 0; k < 16; k++) begin
      cyc(tbl[k].req, tbl[k].last, tbl[k].full);
      chk_out($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].acc, tbl[k].we, tbl[k].cs, tbl[k].din);
    end
    drain_check("tbl_sb", 4, 2, 2, 0);

    // All four requesting, never last: bursts of MAX_BURST in order 0,1,2,3,0.
    begin
      int exp_beat [4];
      int p;
      exp_beat = '{0, 0, 0, 0};
      do_reset(4'b1111);
      for (int g = 0; g < 5; g++) begin
        p = g % 4;
        check($sformatf("rr%0d.idle_gnt", g), 32'(bus.gnt), 32'h0);
        check($sformatf("rr%0d.idle_we", g), 32'(bus.fifo_we), 32'h0);
        for (int b = 0; b < MAX_BURST; b++) begin
          cyc(4'b1111, 4'b0000, 1'b0);
          check($sformatf("rr%0d.gnt", g), 32'(bus.gnt), 32'(4'b0001 << p));
          check($sformatf("rr%0d.we", g), 32'(bus.fifo_we), 32'h1);
          check($sformatf("rr%0d.din", g), bus.fifo_din,
                {8'hD0, 8'(p), 16'(exp_beat[p])});
          exp_beat[p]++;
        end
        cyc(4'b1111, 4'b0000, 1'b0);
      end
      drain_check("rr_sb", 8, 4, 4, 4);
    end

    // Producer 2 stalled by fifo_full for 5 cycles after its first beat.
    do_reset(4'b0100);
    check("st.idle_gnt", 32'(bus.gnt), 32'h0);
    cyc(4'b0100, 4'b0000, 1'b0);
    check("st.b0_we", 32'(bus.fifo_we), 32'h1);
    check("st.b0_din", bus.fifo_din, 32'hD002_0000);
    for (int s = 0; s < 5; s++) begin
      cyc(4'b0100, 4'b0000, 1'b1);
      check($sformatf("st.stall%0d_we", s), 32'(bus.fifo_we), 32'h0);
      check($sformatf("st.stall%0d_acc", s), 32'(bus.accept), 32'h0);
      check($sformatf("st.stall%0d_gnt", s), 32'(bus.gnt), 32'h4);
    end
    for (int b = 1; b < 4; b++) begin
      cyc(4'b0100, 4'b0000, 1'b0);
      check($sformatf("st.b%0d_we", b), 32'(bus.fifo_we), 32'h1);
      check($sformatf("st.b%0d_din", b), bus.fifo_din, 32'hD002_0000 | 32'(b));
    end
    cyc(4'b0100, 4'b0000, 1'b0);
    check("st.release_gnt", 32'(bus.gnt), 32'h0);
    check("st.release_we", 32'(bus.fifo_we), 32'h0);
    drain_check("st_sb", 0, 0, 4, 0);

    // Reset asserted during producer 3's second beat.
    do_reset(4'b1000);
    cyc(4'b1000, 4'b0000, 1'b0);
    check("rs.b0_din", bus.fifo_din, 32'hD003_0000);
    cyc(4'b1000, 4'b0000, 1'b0);
    check("rs.b1_we", 32'(bus.fifo_we), 32'h1);
    drain_check("rs_pre_sb", 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("rs.async", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rs.rel_idle_gnt", 32'(bus.gnt), 32'h0);
    cyc(4'b1000, 4'b0000, 1'b0);
    chk_out("rs.regrant3", 4'b1000, 4'b1000, 1'b1, 1'b1, 32'hD003_0000);
    do_reset(4'b1001);
    check("rs2.idle_gnt", 32'(bus.gnt), 32'h0);
    cyc(4'b1001, 4'b0000, 1'b0);
    chk_out("rs2.regrant0", 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hD000_0000);
    cyc(4'b0000, 4'b0000, 1'b0);
    drain_check("rs_post_sb", 1, 0, 0, 1);

    check("we_while_full", 32'(we_full_seen), 32'h0);
    check("onehot", 32'(onehot_bad), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
